// File: rtl/dec_onehot_pipe_pkg.sv
// dec_pkg: shared constants and helpers for the pipelined one-hot decoder.
//   DEC_MODE_ONEHOT / DEC_MODE_THERMO : encodings of the in_mode input
//   ERR_CNT_W / ERR_CNT_MAX           : width and saturation value of err_cnt
//   split_lo_w / split_hi_w           : split a code width into the two pre-decode halves
package dec_pkg;

  localparam logic DEC_MODE_ONEHOT = 1'b0;
  localparam logic DEC_MODE_THERMO = 1'b1;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  // Low half gets the floor, so the high half is the larger one for odd widths.
  function automatic int split_lo_w(input int in_w);
    return in_w / 2;
  endfunction

  function automatic int split_hi_w(input int in_w);
    return in_w - (in_w / 2);
  endfunction

endpackage

// File: rtl/dec_predecode.sv
// dec_predecode: combinational W-to-2**W pre-decoder.
//   code   in  W       binary input
//   onehot out 2**W    onehot[i] = (code == i)
//   thermo out 2**W    thermo[i] = (code >= i); tied to zero when THERMO_EN = 0
module dec_predecode #(
  parameter int W         = 2,
  parameter bit THERMO_EN = 1'b1
) (
  input  logic [W-1:0]    code,
  output logic [2**W-1:0] onehot,
  output logic [2**W-1:0] thermo
);

  for (genvar gi = 0; gi < 2**W; gi++) begin : g_bit
    assign onehot[gi] = (code == W'(gi));
    if (THERMO_EN) begin : g_th
      assign thermo[gi] = (code >= W'(gi));
    end else begin : g_no_th
      assign thermo[gi] = 1'b0;
    end
  end

endmodule

// File: rtl/dec_onehot_pipe.sv
// dec_onehot_pipe: two-stage binary-to-one-hot decoder with valid/ready flow
// control, range checking and an optional thermometer mode.
// Optional feature macro: DEC_THERMO_EN (in_mode selects thermometer output).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for in_code/in_mode
//   in_code, in_mode     code to decode; mode 0 = one-hot, 1 = thermometer
//   out_valid/out_ready  output handshake
//   out_data             decoded word (all-zero when the code is out of range)
//   out_code, out_err    echoed code and range-error flag
//   err_clr, err_cnt     clear and saturating count of consumed erroneous outputs
module dec_onehot_pipe
  import dec_pkg::*;
#(
  parameter int IN_W    = 7,
  parameter int NUM_OUT = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_OUT-1:0]   out_data,
  output logic [IN_W-1:0]      out_code,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int LO_W = split_lo_w(IN_W);
  localparam int HI_W = split_hi_w(IN_W);
  localparam int LO_N = 2**LO_W;
  localparam int HI_N = 2**HI_W;

`ifdef DEC_THERMO_EN
  localparam bit THERMO_EN = 1'b1;
`else
  localparam bit THERMO_EN = 1'b0;
`endif

  // ---------------- Stage 1: pre-decode and range check ----------------
  logic [LO_N-1:0] lo_oh_next, lo_th_next;
  logic [HI_N-1:0] hi_oh_next, hi_th_next;
  logic            range_err_next;

  dec_predecode #(.W(LO_W), .THERMO_EN(THERMO_EN)) u_pre_lo (
    .code   (in_code[LO_W-1:0]),
    .onehot (lo_oh_next),
    .thermo (lo_th_next)
  );

  dec_predecode #(.W(HI_W), .THERMO_EN(THERMO_EN)) u_pre_hi (
    .code   (in_code[IN_W-1:LO_W]),
    .onehot (hi_oh_next),
    .thermo (hi_th_next)
  );

  // One extra bit so NUM_OUT = 2**IN_W compares correctly (never true).
  assign range_err_next = ({1'b0, in_code} >= (IN_W+1)'(NUM_OUT));

  logic            s1_valid_reg;
  logic [IN_W-1:0] s1_code_reg;
  logic            s1_err_reg;
  logic [LO_N-1:0] lo_oh_reg;
  logic [HI_N-1:0] hi_oh_reg;
  logic            s2_valid_reg;
  logic            s2_ready;
  logic            s1_load;
  logic            s2_load;

  assign s2_ready = !s2_valid_reg | out_ready;
  assign in_ready = !s1_valid_reg | s2_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_reg & s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= '0;
      s1_err_reg   <= 1'b0;
      lo_oh_reg    <= '0;
      hi_oh_reg    <= '0;
    end else begin
      // When in_ready is high, whatever S1 holds is leaving (or S1 is empty).
      if (in_ready) begin
        s1_valid_reg <= in_valid;
      end
      if (s1_load) begin
        s1_code_reg <= in_code;
        s1_err_reg  <= range_err_next;
        lo_oh_reg   <= lo_oh_next;
        hi_oh_reg   <= hi_oh_next;
      end
    end
  end

`ifdef DEC_THERMO_EN
  logic            s1_mode_reg;
  logic [LO_N-1:0] lo_th_reg;
  logic [HI_N-1:0] hi_gt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode_reg <= DEC_MODE_ONEHOT;
      lo_th_reg   <= '0;
      hi_gt_reg   <= '0;
    end else if (s1_load) begin
      s1_mode_reg <= in_mode;
      lo_th_reg   <= lo_th_next;
      // hi_gt[j] = (hi > j): thermometer of hi with its own position removed.
      hi_gt_reg   <= hi_th_next & ~hi_oh_next;
    end
  end
`endif

  // ---------------- Stage 2: combine halves ----------------
  logic [NUM_OUT-1:0] dec_onehot;
  logic [NUM_OUT-1:0] dec_word;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    localparam int HI_IDX = gi / LO_N;
    localparam int LO_IDX = gi % LO_N;
    assign dec_onehot[gi] = hi_oh_reg[HI_IDX] & lo_oh_reg[LO_IDX];
  end

`ifdef DEC_THERMO_EN
  logic [NUM_OUT-1:0] dec_thermo;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_thermo
    localparam int HI_IDX = gi / LO_N;
    localparam int LO_IDX = gi % LO_N;
    assign dec_thermo[gi] = hi_gt_reg[HI_IDX] | (hi_oh_reg[HI_IDX] & lo_th_reg[LO_IDX]);
  end

  // Out-of-range thermometer would otherwise be all ones, so force zero.
  assign dec_word = s1_err_reg ? '0 :
                    (s1_mode_reg == DEC_MODE_THERMO) ? dec_thermo : dec_onehot;
`else
  assign dec_word = s1_err_reg ? '0 : dec_onehot;
`endif

  logic [NUM_OUT-1:0] out_data_reg;
  logic [IN_W-1:0]    out_code_reg;
  logic               out_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      out_data_reg <= '0;
      out_code_reg <= '0;
      out_err_reg  <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (s2_load) begin
        out_data_reg <= dec_word;
        out_code_reg <= s1_code_reg;
        out_err_reg  <= s1_err_reg;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = out_data_reg;
  assign out_code  = out_code_reg;
  assign out_err   = out_err_reg;

  // ---------------- Error counter ----------------
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic                 err_inc;

  assign err_inc = s2_valid_reg & out_ready & out_err_reg;

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr) begin
      // A clear coinciding with an increment counts that increment.
      err_cnt_next = err_inc ? ERR_CNT_W'(1) : '0;
    end else if (err_inc && (err_cnt_reg != ERR_CNT_MAX)) begin
      err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else begin
      err_cnt_reg <= err_cnt_next;
    end
  end

  assign err_cnt = err_cnt_reg;

  // Pre-decode bits beyond NUM_OUT (and the mode input when thermometer
  // decoding is compiled out) intentionally have no load.
  logic unused_bits;
`ifdef DEC_THERMO_EN
  assign unused_bits = ^{lo_oh_reg, hi_oh_reg, lo_th_reg, hi_gt_reg};
`else
  assign unused_bits = ^{in_mode, lo_oh_reg, hi_oh_reg, lo_th_next, hi_th_next};
`endif

endmodule

// File: tb/tb_dec_onehot_pipe.sv
module tb_dec_onehot_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_code;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [99:0] out_data;
  logic [6:0]  out_code;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_cnt;

  logic        sm_in_valid;
  logic        sm_in_ready;
  logic [3:0]  sm_in_code;
  logic        sm_in_mode;
  logic        sm_out_valid;
  logic        sm_out_ready;
  logic [15:0] sm_out_data;
  logic [3:0]  sm_out_code;
  logic        sm_out_err;
  logic        sm_err_clr;
  logic [7:0]  sm_err_cnt;

  int tests_run;
  int tests_failed;

  dec_onehot_pipe #(.IN_W(7), .NUM_OUT(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  dec_onehot_pipe #(.IN_W(4), .NUM_OUT(16)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sm_in_valid),
    .in_ready  (sm_in_ready),
    .in_code   (sm_in_code),
    .in_mode   (sm_in_mode),
    .out_valid (sm_out_valid),
    .out_ready (sm_out_ready),
    .out_data  (sm_out_data),
    .out_code  (sm_out_code),
    .out_err   (sm_out_err),
    .err_clr   (sm_err_clr),
    .err_cnt   (sm_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one code into an empty pipeline; returns with its output presented.
  task automatic send_one(input logic [6:0] code, input logic mode);
    in_valid = 1'b1;
    in_code  = code;
    in_mode  = mode;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_code !== '0 || out_err !== 1'b0 ||
        err_cnt !== 8'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b data=%h code=%0d err=%b cnt=%0d rdy=%b, required 0/0/0/0/0/1",
               out_valid, out_data, out_code, out_err, err_cnt, in_ready);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_release: rdy=%b valid=%b, required 1/0", in_ready, out_valid);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    logic [99:0] exp;
    exp = '0;
    exp[0] = 1'b1;
    in_valid = 1'b1;
    in_code  = 7'd0;
    in_mode  = 1'b0;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_lat1: out_valid=%b, required 0", out_valid);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0 || out_code !== 7'd0) begin
      tests_failed++;
      $display("FAIL single_code0: valid=%b data=%h err=%b code=%0d, required 1/%h/0/0",
               out_valid, out_data, out_err, out_code, exp);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: out_valid=%b, required 0", out_valid);
    end
    $display("[TB] single code 0 -> data=%h", exp);
  endtask

  task automatic test_stream();
    logic [99:0] exp;
    for (int cyc = 0; cyc <= 101; cyc++) begin
      in_valid = (cyc < 100);
      in_code  = 7'(cyc % 128);
      in_mode  = 1'b0;
      step();
      if (cyc >= 1 && cyc <= 100) begin
        exp = '0;
        exp[cyc-1] = 1'b1;
        tests_run++;
        if (out_valid !== 1'b1 || out_code !== 7'(cyc-1) || out_data !== exp || out_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_%0d: valid=%b code=%0d err=%b data=%h, required 1/%0d/0/%h",
                   cyc-1, out_valid, out_code, out_err, out_data, cyc-1, exp);
        end
      end else begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_idle_%0d: out_valid=%b, required 0", cyc, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    $display("[TB] stream of 100 codes done");
  endtask

  task automatic test_thermo();
    logic [99:0] exp;
    exp = '0;
`ifdef DEC_THERMO_EN
    for (int i = 0; i <= 37; i++) exp[i] = 1'b1;
`else
    exp[37] = 1'b1;
`endif
    send_one(7'd37, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0 || out_code !== 7'd37) begin
      tests_failed++;
      $display("FAIL thermo_37: valid=%b data=%h err=%b code=%0d, required 1/%h/0/37",
               out_valid, out_data, out_err, out_code, exp);
    end
    step();
    $display("[TB] mode=1 code 37 -> data=%h", exp);
  endtask

  task automatic test_boundary();
    logic [99:0] exp;
    exp = '0;
    exp[99] = 1'b1;
    send_one(7'd99, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL onehot_99: valid=%b data=%h err=%b, required 1/%h/0",
               out_valid, out_data, out_err, exp);
    end
    step();
`ifdef DEC_THERMO_EN
    exp = '1;
`endif
    send_one(7'd99, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== exp || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL thermo_99: valid=%b data=%h err=%b, required 1/%h/0",
               out_valid, out_data, out_err, exp);
    end
    step();
    $display("[TB] boundary code 99 checked in both modes");
  endtask

  task automatic test_errors();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL err_start: err_cnt=%0d, required 0", err_cnt);
    end
    send_one(7'd100, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== '0 || out_err !== 1'b1 || out_code !== 7'd100) begin
      tests_failed++;
      $display("FAIL err_100: valid=%b data=%h err=%b code=%0d, required 1/0/1/100",
               out_valid, out_data, out_err, out_code);
    end
    send_one(7'd127, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== '0 || out_err !== 1'b1 || out_code !== 7'd127) begin
      tests_failed++;
      $display("FAIL err_127: valid=%b data=%h err=%b code=%0d, required 1/0/1/127",
               out_valid, out_data, out_err, out_code);
    end
    step();
    tests_run++;
    if (err_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL err_cnt_2: err_cnt=%0d, required 2", err_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_code  = 7'(100 + (i % 28));
      in_mode  = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    tests_run++;
    if (err_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL err_cnt_sat: err_cnt=%0d, required 255", err_cnt);
    end
    send_one(7'd110, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL err_clr_inc: err_cnt=%0d, required 1", err_cnt);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (err_cnt !== 8'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clr_alone: err_cnt=%0d valid=%b, required 0/0", err_cnt, out_valid);
    end
    $display("[TB] error counting and clear checked");
  endtask

  task automatic test_back_to_back_stall();
    logic [99:0] exp;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_code   = 7'd3;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept3: in_ready=%b, required 1", in_ready);
    end
    step();
    in_code = 7'd4;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept4: in_ready=%b, required 1", in_ready);
    end
    step();
    in_code = 7'd5;
    exp = '0;
    exp[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 7'd3 || out_data !== exp) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: rdy=%b valid=%b code=%0d data=%h, required 0/1/3/%h",
                 k, in_ready, out_valid, out_code, out_data, exp);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    exp = '0;
    exp[4] = 1'b1;
    tests_run++;
    if (out_valid !== 1'b1 || out_code !== 7'd4 || out_data !== exp) begin
      tests_failed++;
      $display("FAIL bp_out4: valid=%b code=%0d data=%h, required 1/4/%h",
               out_valid, out_code, out_data, exp);
    end
    step();
    exp = '0;
    exp[5] = 1'b1;
    tests_run++;
    if (out_valid !== 1'b1 || out_code !== 7'd5 || out_data !== exp) begin
      tests_failed++;
      $display("FAIL bp_out5: valid=%b code=%0d data=%h, required 1/5/%h",
               out_valid, out_code, out_data, exp);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_no_dup: out_valid=%b code=%0d, required valid 0", out_valid, out_code);
    end
    $display("[TB] backpressure 3,4,5 checked");
  endtask

  task automatic test_reset_midflight();
    send_one(7'd100, 1'b0);
    step();
    tests_run++;
    if (err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL mid_pre_cnt: err_cnt=%0d, required 1", err_cnt);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 7'd20;
    step();
    in_code = 7'd21;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_full: valid=%b rdy=%b, required 1/0", out_valid, in_ready);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL mid_async_rst: valid=%b cnt=%0d rdy=%b data=%h, required 0/0/1/0",
               out_valid, err_cnt, in_ready, out_data);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_stale_%0d: out_valid=%b code=%0d, required valid 0", k, out_valid, out_code);
      end
    end
    $display("[TB] reset while full checked");
  endtask

  task automatic test_small_exhaustive();
    logic [15:0] exp;
    sm_out_ready = 1'b1;
    for (int cyc = 0; cyc <= 17; cyc++) begin
      sm_in_valid = (cyc < 16);
      sm_in_code  = 4'(cyc % 16);
      step();
      if (cyc >= 1 && cyc <= 16) begin
        exp = '0;
        exp[cyc-1] = 1'b1;
        tests_run++;
        if (sm_out_valid !== 1'b1 || sm_out_code !== 4'(cyc-1) || sm_out_data !== exp || sm_out_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL small_%0d: valid=%b code=%0d err=%b data=%h, required 1/%0d/0/%h",
                   cyc-1, sm_out_valid, sm_out_code, sm_out_err, sm_out_data, cyc-1, exp);
        end
      end
    end
    sm_in_valid = 1'b0;
    tests_run++;
    if (sm_out_valid !== 1'b0 || sm_err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL small_end: valid=%b err_cnt=%0d, required 0/0", sm_out_valid, sm_err_cnt);
    end
    $display("[TB] small instance 16 codes checked");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_code      = '0;
    in_mode      = 1'b0;
    out_ready    = 1'b1;
    err_clr      = 1'b0;
    sm_in_valid  = 1'b0;
    sm_in_code   = '0;
    sm_in_mode   = 1'b0;
    sm_out_ready = 1'b1;
    sm_err_clr   = 1'b0;

    test_reset();
    test_single();
    test_stream();
    test_thermo();
    test_boundary();
    test_errors();
    test_back_to_back_stall();
    test_reset_midflight();
    test_small_exhaustive();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
